// File: rtl/pe_result_monitor_pkg.sv
// pe_mon_pkg: shared FSM states, MISR taps and report flag type for the PE result monitor.
package pe_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic [15:0] MISR_TAP = 16'hD008;
  typedef struct packed {
    logic err_seen;
    logic sat;
    logic drop;
  } rpt_flags_t;
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] d);
    return {sig[14:0], ^(sig & MISR_TAP)} ^ d;
  endfunction
endpackage

// File: rtl/pe_result_monitor_if.sv
// pe_result_monitor_if: result stream in, report handshake out; rpt_sig exists only with PE_MON_SIGNATURE_EN.
interface pe_result_monitor_if #(
  parameter int RES_WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8,
  parameter int IDX_W = 4
);
  logic start, res_valid, err1, err2, busy, rpt_valid, rpt_ready;
  logic rpt_err_seen, rpt_sat, drop;
  logic [RES_WIDTH-1:0] res_data;
  logic [ACC_WIDTH-1:0] rpt_sum;
  logic [CNT_WIDTH-1:0] rpt_err1_cnt, rpt_err2_cnt;
  logic [IDX_W-1:0] rpt_first_err;
`ifdef PE_MON_SIGNATURE_EN
  logic [15:0] rpt_sig;
`endif
  modport master (
    output start, res_valid, res_data, err1, err2, rpt_ready,
    input busy, rpt_valid, rpt_sum, rpt_err1_cnt, rpt_err2_cnt, rpt_first_err, rpt_err_seen, rpt_sat, drop
`ifdef PE_MON_SIGNATURE_EN
    , rpt_sig
`endif
  );
  modport slave (
    input start, res_valid, res_data, err1, err2, rpt_ready,
    output busy, rpt_valid, rpt_sum, rpt_err1_cnt, rpt_err2_cnt, rpt_first_err, rpt_err_seen, rpt_sat, drop
`ifdef PE_MON_SIGNATURE_EN
    , rpt_sig
`endif
  );
endinterface

// File: rtl/pe_result_monitor_sat_counter.sv
// pe_sat_counter: clearable up-counter that holds at all-ones.
module pe_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (inc && !(&cnt)) ? cnt + WIDTH'(1) : cnt;
endmodule

// File: rtl/pe_result_monitor.sv
// pe_result_monitor: per-job saturating sum, error counts and first-error index of the PE result stream.
// Optional MISR signature output rpt_sig enabled by PE_MON_SIGNATURE_EN.
module pe_result_monitor
  import pe_mon_pkg::*;
#(
  parameter int DATA_NUM  = 16,
  parameter int RES_WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  pe_result_monitor_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_NUM);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx, first_err;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH:0] sum_ext;
  logic [CNT_WIDTH-1:0] cnt1, cnt2;
  logic clr, acc, last;
  rpt_flags_t flags;
  // start in HOLD only takes effect together with the report transfer
  assign clr = bus.start && (state != HOLD || bus.rpt_ready);
  assign acc = state == ACCUM && !clr;
  assign last = acc && bus.res_valid && idx == IDX_W'(DATA_NUM - 1);
  assign sum_ext = {1'b0, sum} + (ACC_WIDTH + 1)'(bus.res_data);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = clr ? ACCUM : last ? HOLD : (state == HOLD && bus.rpt_ready) ? IDLE : state;
    bus.busy = state == ACCUM;
    bus.rpt_valid = state == HOLD;
  end
  always_ff @(posedge clk)
    if (rst || clr) begin
      sum <= '0;
      idx <= '0;
      first_err <= '0;
      flags <= '0;
    end else begin
      if (acc && bus.res_valid) begin
        sum <= sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
        flags.sat <= flags.sat | sum_ext[ACC_WIDTH];
        idx <= last ? '0 : idx + IDX_W'(1);
      end
      if (acc && (bus.err1 || bus.err2) && !flags.err_seen) begin
        first_err <= idx;
        flags.err_seen <= 1'b1;
      end
      if (state != ACCUM && bus.res_valid) flags.drop <= 1'b1;
    end
`ifdef PE_MON_SIGNATURE_EN
  logic [15:0] sig;
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (acc && bus.res_valid) sig <= misr_next(sig, 16'(bus.res_data));
  assign bus.rpt_sig = sig;
`endif
  pe_sat_counter #(.WIDTH(CNT_WIDTH)) u_err1 (.clk(clk), .rst(rst), .clr(clr), .inc(acc && bus.err1), .cnt(cnt1));
  pe_sat_counter #(.WIDTH(CNT_WIDTH)) u_err2 (.clk(clk), .rst(rst), .clr(clr), .inc(acc && bus.err2), .cnt(cnt2));
  assign bus.rpt_sum = sum;
  assign bus.rpt_err1_cnt = cnt1;
  assign bus.rpt_err2_cnt = cnt2;
  assign bus.rpt_first_err = first_err;
  assign bus.rpt_err_seen = flags.err_seen;
  assign bus.rpt_sat = flags.sat;
  assign bus.drop = flags.drop;
endmodule

// File: tb/tb_pe_result_monitor.sv
// tb_pe_result_monitor: drives a default DUT and a narrow (ACC 16 / CNT 2) DUT with the same stimulus, checked against a job-level model.
module tb_pe_result_monitor;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  pe_result_monitor_if i0 ();
  pe_result_monitor_if #(.ACC_WIDTH(16), .CNT_WIDTH(2)) i1 ();
  pe_result_monitor u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  pe_result_monitor #(.ACC_WIDTH(16), .CNT_WIDTH(2)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  int checks = 0, failures = 0;
  bit en = 0;
  bit st, v, e1, e2, rdy;
  logic [15:0] d;
  int ph, n, c1, c2, fe;
  longint tot;
  bit seen, drop;
  logic [15:0] sig;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  function automatic longint cap(input longint x, input longint m);
    return x > m ? m : x;
  endfunction
  task automatic clear_model();
    tot = 0; n = 0; c1 = 0; c2 = 0; fe = 0; seen = 0; drop = 0; sig = 0;
  endtask
  // job-level view: results arrive in jobs of 16, totals kept unbounded and capped at compare time
  task automatic model_step();
    if (rst) begin
      clear_model();
      ph = 0;
    end else if (st && (ph != 2 || rdy)) begin
      clear_model();
      ph = 1;
    end else if (ph == 1) begin
      c1 += int'(e1);
      c2 += int'(e2);
      if ((e1 || e2) && !seen) begin seen = 1; fe = n; end
      if (v) begin
        tot += longint'(d);
        sig = {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]} ^ d;
        n++;
        if (n == 16) begin ph = 2; n = 0; end
      end
    end else begin
      if (v) drop = 1;
      if (ph == 2 && rdy) ph = 0;
    end
  endtask
  task automatic cyc(input bit r, input bit s, input bit vv, input logic [15:0] dd, input bit a1, input bit a2, input bit rr);
    rst = r; st = s; v = vv; d = dd; e1 = a1; e2 = a2; rdy = rr;
    i0.start = s; i0.res_valid = vv; i0.res_data = dd; i0.err1 = a1; i0.err2 = a2; i0.rpt_ready = rr;
    i1.start = s; i1.res_valid = vv; i1.res_data = dd; i1.err1 = a1; i1.err2 = a2; i1.rpt_ready = rr;
    @(posedge clk);
    model_step();
    #1;
    en = 1;
  endtask
  always @(negedge clk) if (en) begin
    chk("busy0", i0.busy, ph == 1);
    chk("valid0", i0.rpt_valid, ph == 2);
    chk("sum0", i0.rpt_sum, cap(tot, 64'hFFFFFF));
    chk("sat0", i0.rpt_sat, tot > 64'hFFFFFF);
    chk("c1_0", i0.rpt_err1_cnt, cap(c1, 255));
    chk("c2_0", i0.rpt_err2_cnt, cap(c2, 255));
    chk("fe0", i0.rpt_first_err, fe);
    chk("seen0", i0.rpt_err_seen, seen);
    chk("drop0", i0.drop, drop);
    chk("busy1", i1.busy, ph == 1);
    chk("valid1", i1.rpt_valid, ph == 2);
    chk("sum1", i1.rpt_sum, cap(tot, 64'hFFFF));
    chk("sat1", i1.rpt_sat, tot > 64'hFFFF);
    chk("c1_1", i1.rpt_err1_cnt, cap(c1, 3));
    chk("c2_1", i1.rpt_err2_cnt, cap(c2, 3));
    chk("fe1", i1.rpt_first_err, fe);
    chk("drop1", i1.drop, drop);
`ifdef PE_MON_SIGNATURE_EN
    chk("sig0", i0.rpt_sig, sig);
    chk("sig1", i1.rpt_sig, sig);
`endif
  end
  initial begin
    ph = 0;
    clear_model();
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_sum", i0.rpt_sum, 0);
    chk("rst_valid", i0.rpt_valid, 0);
    chk("rst_busy", i0.busy, 0);
    // nominal job
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("nom_busy", i0.busy, 1);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 16'h0100, 0, 0, 0);
    chk("nom_valid", i0.rpt_valid, 1);
    chk("nom_sum", i0.rpt_sum, 24'h001000);
    chk("nom_seen", i0.rpt_err_seen, 0);
    chk("nom_sat", i0.rpt_sat, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("nom_idle", i0.rpt_valid, 0);
    chk("nom_persist", i0.rpt_sum, 24'h001000);
    // error tracking
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 16'(k), k >= 3 && k <= 5, k == 9, 0);
    chk("err_c1", i0.rpt_err1_cnt, 3);
    chk("err_c2", i0.rpt_err2_cnt, 1);
    chk("err_fe", i0.rpt_first_err, 3);
    chk("err_seen", i0.rpt_err_seen, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // saturation on the narrow instance
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 16'hFFFF, k < 6, 0, 0);
    chk("sat_sum1", i1.rpt_sum, 16'hFFFF);
    chk("sat_sat1", i1.rpt_sat, 1);
    chk("sat_c1_1", i1.rpt_err1_cnt, 3);
    chk("sat_sum0", i0.rpt_sum, 24'h0FFFF0);
    chk("sat_c1_0", i0.rpt_err1_cnt, 6);
    // backpressure with stray strobes
    for (int k = 0; k < 10; k++) cyc(0, 0, k[0], 16'($urandom), 0, 0, 0);
    chk("bp_valid", i0.rpt_valid, 1);
    chk("bp_drop", i0.drop, 1);
    chk("bp_sum", i0.rpt_sum, 24'h0FFFF0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("bp_busy", i0.busy, 1);
    chk("bp_drop_clr", i0.drop, 0);
    // restart mid-job
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 16'($urandom), 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 16'd1, 0, 0, 0);
    chk("rs_sum", i0.rpt_sum, 16);
    chk("rs_valid", i0.rpt_valid, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // reset mid-job
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 16'd7, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rr_sum", i0.rpt_sum, 0);
    chk("rr_c1", i0.rpt_err1_cnt, 0);
    chk("rr_valid", i0.rpt_valid, 0);
    chk("rr_busy", i0.busy, 0);
`ifdef PE_MON_SIGNATURE_EN
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("sig_clr", i0.rpt_sig, 16'h0000);
    cyc(0, 0, 1, 16'h0001, 0, 0, 0);
    chk("sig_a", i0.rpt_sig, 16'h0001);
    cyc(0, 0, 1, 16'h0002, 0, 0, 0);
    chk("sig_b", i0.rpt_sig, 16'h0000);
    for (int k = 0; k < 14; k++) cyc(0, 0, 1, 16'($urandom), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
`endif
    // randomized traffic
    for (int k = 0; k < 2500; k++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
